// File: rtl/lc3_control_unit.sv
// rtl/lc3_control_unit.sv - LC-3 ISDU Moore sequencer: fetch, decode, execute.
// Define FETCH_PAUSE_EN to add a Continue-gated pause between S35 and S32.
module lc3_control_unit #(
    parameter int MEM_WAIT_CYCLES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic       MIO_EN,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam logic [2:0] LAST_WAIT = 3'(MEM_WAIT_CYCLES - 1);

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32,
        S01, S05, S09, S00, S22, S12, S04, S21, S20,
        S06, S25, S27, S07, S23, S16,
        PAUSE_A, PAUSE_B
`ifdef FETCH_PAUSE_EN
        , FETCH_PAUSE_A, FETCH_PAUSE_B
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= HALTED;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HALTED:  if (Run) state_d = S18;
            S18:     state_d = S33;
            S33:     if (cnt_q == LAST_WAIT) state_d = S35;
`ifdef FETCH_PAUSE_EN
            S35:           state_d = FETCH_PAUSE_A;
            FETCH_PAUSE_A: if (Continue) state_d = FETCH_PAUSE_B;
            FETCH_PAUSE_B: if (!Continue) state_d = S32;
`else
            S35:     state_d = S32;
`endif
            S32: begin
                unique case (Opcode)
                    4'b0001: state_d = S01;
                    4'b0101: state_d = S05;
                    4'b1001: state_d = S09;
                    4'b0000: state_d = S00;
                    4'b1100: state_d = S12;
                    4'b0100: state_d = S04;
                    4'b0110: state_d = S06;
                    4'b0111: state_d = S07;
                    4'b1101: state_d = PAUSE_A;
                    default: state_d = S18;
                endcase
            end
            S00:     state_d = BEN ? S22 : S18;
            S04:     state_d = IR_11 ? S21 : S20;
            S06:     state_d = S25;
            S25:     if (cnt_q == LAST_WAIT) state_d = S27;
            S07:     state_d = S23;
            S23:     state_d = S16;
            S16:     if (cnt_q == LAST_WAIT) state_d = S18;
            PAUSE_A: if (Continue) state_d = PAUSE_B;
            PAUSE_B: if (!Continue) state_d = S18;
            default: state_d = S18;
        endcase
    end

    // Counter is zero on entry to any wait/pause state; in PAUSE_A it marks the entry cycle.
    always_comb begin
        cnt_d = 3'd0;
        if (state_d == state_q) begin
            unique case (state_q)
                S33, S25, S16: cnt_d = cnt_q + 3'd1;
                PAUSE_A:       cnt_d = 3'd1;
                default:       cnt_d = 3'd0;
            endcase
        end
    end

    always_comb begin
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
        LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0; ADDR1MUX = 1'b0; MIO_EN = 1'b0;
        PCMUX = 2'b00; ADDR2MUX = 2'b00; ALUK = 2'b00;
        Mem_OE = 1'b1; Mem_WE = 1'b1;
        unique case (state_q)
            S18: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
            S33, S25: begin
                MIO_EN = 1'b1;
                Mem_OE = 1'b0;
                LD_MDR = (cnt_q == LAST_WAIT);
            end
            S35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
            S32: LD_BEN = 1'b1;
            S01, S05, S09: begin
                SR1MUX = 1'b1;
                SR2MUX = IR_5;
                ALUK = (state_q == S05) ? 2'b01 : (state_q == S09) ? 2'b10 : 2'b00;
                GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
            end
            S22: begin ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1; end
            S12, S20: begin
                SR1MUX = 1'b1; ALUK = 2'b11; GateALU = 1'b1; PCMUX = 2'b01; LD_PC = 1'b1;
            end
            S04: begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
            S21: begin ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1'b1; end
            S06, S07: begin
                SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
                GateMARMUX = 1'b1; LD_MAR = 1'b1;
            end
            S27: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
            S23: begin ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1; end
            S16: Mem_WE = 1'b0;
            PAUSE_A: LD_LED = (cnt_q == 3'd0);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_unit.sv
// tb/tb_lc3_control_unit.sv - self-checking bench for lc3_control_unit (default build).
module tb_lc3_control_unit;

    localparam int MW = 2;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic drmux, sr1mux, sr2mux, addr1mux, mio_en;
        logic [1:0] pcmux, addr2mux, aluk;
        logic mem_oe, mem_we;
    } ctl_t;

    typedef struct {
        logic [3:0] op;
        logic       ir5, ir11, ben;
        int         cycles;
    } vec_t;

    logic       Clk = 1'b0, Reset = 1'b1, Run = 1'b0, Continue = 1'b0;
    logic [3:0] Opcode = 4'b0000;
    logic       IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0;
    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic Mem_OE, Mem_WE;

    lc3_control_unit #(.MEM_WAIT_CYCLES(MW)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
        .MIO_EN(MIO_EN), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    always #5 Clk = ~Clk;

    ctl_t act;
    assign act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX,
                  DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
                  PCMUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

    int   tests = 0;
    int   fails = 0;
    ctl_t exp_q[$];

    function automatic ctl_t idle();
        ctl_t c;
        c = '0;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        return c;
    endfunction

    function automatic ctl_t fetch_sig();
        ctl_t c;
        c = idle();
        c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1;
        return c;
    endfunction

    function automatic ctl_t read_sig(input bit last);
        ctl_t c;
        c = idle();
        c.mio_en = 1'b1; c.mem_oe = 1'b0; c.ld_mdr = last;
        return c;
    endfunction

    task automatic check(input string name, input ctl_t a, input ctl_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, a, e);
        end
        tests++;
        if ((!a.mem_oe && !a.mem_we) ||
            (int'(a.gate_pc) + int'(a.gate_mdr) + int'(a.gate_alu) + int'(a.gate_marmux) > 1)) begin
            fails++;
            $display("FAIL %s_invariant: actual=%h required=exclusive gates and strobes", name, a);
        end
    endtask

    // Expected per-cycle control words for one instruction, fetch through the last execute cycle.
    task automatic build(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben);
        ctl_t c;
        exp_q.delete();
        exp_q.push_back(fetch_sig());
        for (int i = 0; i < MW; i++) exp_q.push_back(read_sig(i == MW - 1));
        c = idle(); c.gate_mdr = 1'b1; c.ld_ir = 1'b1; exp_q.push_back(c);
        c = idle(); c.ld_ben = 1'b1; exp_q.push_back(c);
        case (op)
            4'b0001, 4'b0101, 4'b1001: begin
                c = idle(); c.sr1mux = 1'b1; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                c.sr2mux = ir5;
                c.aluk = (op == 4'b0101) ? 2'd1 : (op == 4'b1001) ? 2'd2 : 2'd0;
                exp_q.push_back(c);
            end
            4'b0000: begin
                exp_q.push_back(idle());
                if (ben) begin
                    c = idle(); c.addr2mux = 2'd2; c.pcmux = 2'd2; c.ld_pc = 1'b1;
                    exp_q.push_back(c);
                end
            end
            4'b1100: begin
                c = idle(); c.sr1mux = 1'b1; c.aluk = 2'd3; c.gate_alu = 1'b1;
                c.pcmux = 2'd1; c.ld_pc = 1'b1;
                exp_q.push_back(c);
            end
            4'b0100: begin
                c = idle(); c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1;
                exp_q.push_back(c);
                c = idle(); c.ld_pc = 1'b1;
                if (ir11) begin
                    c.addr2mux = 2'd3; c.pcmux = 2'd2;
                end else begin
                    c.sr1mux = 1'b1; c.aluk = 2'd3; c.gate_alu = 1'b1; c.pcmux = 2'd1;
                end
                exp_q.push_back(c);
            end
            4'b0110, 4'b0111: begin
                c = idle(); c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'd1;
                c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
                exp_q.push_back(c);
                if (op == 4'b0110) begin
                    for (int i = 0; i < MW; i++) exp_q.push_back(read_sig(i == MW - 1));
                    c = idle(); c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                    exp_q.push_back(c);
                end else begin
                    c = idle(); c.aluk = 2'd3; c.gate_alu = 1'b1; c.ld_mdr = 1'b1;
                    exp_q.push_back(c);
                    c = idle(); c.mem_we = 1'b0;
                    for (int i = 0; i < MW; i++) exp_q.push_back(c);
                end
            end
            default: ;
        endcase
    endtask

    // Entered at the negedge of an S18 cycle; leaves at the negedge of the next S18.
    task automatic run_instr(input string name, input logic [3:0] op, input logic ir5,
                             input logic ir11, input logic ben, output int cycles);
        Opcode = op; IR_5 = ir5; IR_11 = ir11; BEN = ben;
        build(op, ir5, ir11, ben);
        cycles = 0;
        do begin
            if (cycles < exp_q.size()) check(name, act, exp_q[cycles]);
            @(negedge Clk);
            cycles++;
        end while (act !== fetch_sig() && cycles < 40);
        tests++;
        if (cycles != exp_q.size()) begin
            fails++;
            $display("FAIL %s_length: actual=%0d cycles required=%0d", name, cycles, exp_q.size());
        end
    endtask

    vec_t vecs[$];
    int   n;
    ctl_t c;
    logic [3:0] rop;

    initial begin
        vecs.push_back('{4'b0001, 1'b1, 1'b0, 1'b0, 6});
        vecs.push_back('{4'b0001, 1'b0, 1'b0, 1'b0, 6});
        vecs.push_back('{4'b0101, 1'b1, 1'b0, 1'b0, 6});
        vecs.push_back('{4'b1001, 1'b0, 1'b0, 1'b0, 6});
        vecs.push_back('{4'b0000, 1'b0, 1'b0, 1'b1, 7});
        vecs.push_back('{4'b0000, 1'b0, 1'b0, 1'b0, 6});
        vecs.push_back('{4'b1100, 1'b0, 1'b0, 1'b0, 6});
        vecs.push_back('{4'b0100, 1'b0, 1'b1, 1'b0, 7});
        vecs.push_back('{4'b0100, 1'b0, 1'b0, 1'b0, 7});
        vecs.push_back('{4'b0110, 1'b0, 1'b0, 1'b0, 9});
        vecs.push_back('{4'b0111, 1'b0, 1'b0, 1'b0, 9});
        vecs.push_back('{4'b1111, 1'b0, 1'b0, 1'b0, 5});
        vecs.push_back('{4'b0010, 1'b1, 1'b1, 1'b1, 5});

        // Reset held two edges, then Halted must persist until Run.
        @(posedge Clk); @(posedge Clk);
        @(negedge Clk);
        check("reset_halted", act, idle());
        Reset = 1'b0;
        @(negedge Clk);
        check("halted_hold", act, idle());
        @(negedge Clk);
        check("halted_hold2", act, idle());
        Run = 1'b1;
        @(negedge Clk);
        check("run_to_s18", act, fetch_sig());

        foreach (vecs[i]) begin
            run_instr($sformatf("vec%0d_op%b", i, vecs[i].op), vecs[i].op, vecs[i].ir5,
                      vecs[i].ir11, vecs[i].ben, n);
            tests++;
            if (n != vecs[i].cycles) begin
                fails++;
                $display("FAIL vec%0d_f2f: actual=%0d required=%0d", i, n, vecs[i].cycles);
            end
        end

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            if (rop == 4'b1101) rop = 4'b0001;
            run_instr($sformatf("rand%0d_op%b", i, rop), rop, 1'($urandom),
                      1'($urandom), 1'($urandom), n);
        end

        // PSE: LED pulse once, then Continue 0->1->0 handshake.
        Continue = 1'b0;
        Opcode = 4'b1101;
        build(4'b1101, 1'b0, 1'b0, 1'b0);
        foreach (exp_q[k]) begin
            check("pse_fetch", act, exp_q[k]);
            @(negedge Clk);
        end
        c = idle(); c.ld_led = 1'b1;
        check("pse_led", act, c);
        @(negedge Clk);
        check("pse_led_once", act, idle());
        @(negedge Clk);
        check("pse_waitA", act, idle());
        Continue = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check("pse_holdB", act, idle());
        end
        Continue = 1'b0;
        @(negedge Clk);
        check("pse_resume", act, fetch_sig());

        // Reset in the final fetch-read cycle must abort to Halted.
        Opcode = 4'b0001;
        @(negedge Clk);
        check("rst_s33a", act, read_sig(1'b0));
        @(negedge Clk);
        check("rst_s33b", act, read_sig(1'b1));
        Reset = 1'b1;
        @(negedge Clk);
        check("rst_mid_halted", act, idle());
        Reset = 1'b0;
        Run = 1'b0;
        @(negedge Clk);
        check("rst_mid_hold", act, idle());
        Run = 1'b1;
        @(negedge Clk);
        check("rst_restart", act, fetch_sig());
        run_instr("post_reset_add", 4'b0001, 1'b1, 1'b0, 1'b0, n);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
